gcd_arbiter: RTL and testbench

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_arbiter.sv | 102 ++++++++++
 tb/tb_gcd_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter sharing one external GCD engine among N_REQ requesters
// Ports: clk, rst (async, active-high); req/opa/opb per-requester request and packed operands;
//        gnt/rsp_valid one-hot pulses, rsp_data result, busy; eng_start/eng_a/eng_b drive the
//        engine, eng_done/eng_result return from it.
// Optional: GCD_ARB_ZERO_BYPASS_EN answers pairs with a zero operand directly (opa|opb) without the engine.
module gcd_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] opa,
  input  logic [N_REQ*W-1:0] opb,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               busy,
  output logic               eng_start,
  output logic [W-1:0]       eng_a,
  output logic [W-1:0]       eng_b,
  input  logic               eng_done,
  input  logic [W-1:0]       eng_result
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [PW-1:0] ptr, win, pick, idx, pick_nx, win_nx;
  logic [N_REQ-1:0] pick_oh, win_oh;
  logic [W-1:0] a, b;
  logic byp;
  // descending scan so the last hit is the first requester at or above ptr
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end
  assign a = opa[pick*W +: W];
  assign b = opb[pick*W +: W];
  assign pick_oh = N_REQ'(1) << pick;
  assign win_oh = N_REQ'(1) << win;
  assign pick_nx = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
  assign win_nx = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
  assign byp = (a == '0) || (b == '0);
`else
  assign byp = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      eng_start <= 1'b0;
      eng_a <= '0;
      eng_b <= '0;
      busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|req) begin
          win <= pick;
          gnt <= pick_oh;
          busy <= 1'b1;
          if (byp) begin
            rsp_valid <= pick_oh;
            rsp_data <= a | b;
            ptr <= pick_nx;
            state <= RESP;
          end else begin
            eng_a <= a;
            eng_b <= b;
            eng_start <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          gnt <= '0;
          eng_start <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (eng_done) begin
          rsp_data <= eng_result;
          rsp_valid <= win_oh;
          ptr <= win_nx;
          state <= RESP;
        end
        RESP: begin
          gnt <= '0;
          rsp_valid <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: self-checking bench for gcd_arbiter with a behavioural GCD engine model
module tb_gcd_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] opa = '0, opb = '0;
  logic [3:0] gnt, rsp_valid;
  logic [15:0] rsp_data, eng_a, eng_b;
  logic busy, eng_start;
  logic eng_done = 1'b0;
  logic [15:0] eng_result = '0;
  int tests = 0, fails = 0, model_ptr = 0, eng_delay = 1, cnt = 0, cyc = 0, rv_cnt = 0;
  bit eng_auto = 1'b1;
  typedef struct {
    logic [3:0] r;
    logic [15:0] a, b;
    int d, w;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[6];

  gcd_arbiter #(.N_REQ(4), .W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .eng_start(eng_start),
    .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    if (|rsp_valid) rv_cnt++;
  end

  function automatic logic [15:0] gcd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // engine: done pulses for one cycle eng_delay cycles after eng_start
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      cnt = 0;
      if (eng_auto) eng_done = 1'b0;
    end else if (eng_auto) begin
      if (cnt > 0) begin
        cnt--;
        eng_done = (cnt == 0);
        if (cnt == 0) eng_result = gcd(eng_a, eng_b);
      end else eng_done = 1'b0;
      if (eng_start) cnt = eng_delay;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check(nm, {gnt, rsp_valid, rsp_data, busy, eng_start, eng_a, eng_b}, 64'd0);
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1;
    req = r;
    #1;
    check_zero("reset outputs");
    tick;
    tick;
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic run_txn(input logic [3:0] r, input logic [63:0] a, input logic [63:0] b,
                         input int d, input int ew, input logic [15:0] ed, input string nm);
    bit byp;
    int n;
    byp = 1'b0;
`ifdef GCD_ARB_ZERO_BYPASS_EN
    byp = (a[ew*16 +: 16] == 0) || (b[ew*16 +: 16] == 0);
`endif
    opa = a;
    opb = b;
    eng_delay = d;
    req = r;
    tick;
    check({nm, " gnt"}, gnt, 64'(1 << ew));
    check({nm, " busy"}, busy, 1);
    check({nm, " eng_start"}, eng_start, byp ? 0 : 1);
    req = '0;
    if (!byp) begin
      n = 0;
      while (rsp_valid == 0 && n < d + 10) begin
        tick;
        n++;
      end
      check({nm, " latency"}, n, d + 1);
    end
    check({nm, " rsp_valid"}, rsp_valid, 64'(1 << ew));
    check({nm, " rsp_data"}, rsp_data, ed);
    tick;
    check({nm, " idle"}, {busy, rsp_valid, gnt}, 0);
    check({nm, " hold"}, rsp_data, ed);
    model_ptr = (ew + 1) % 4;
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [3:0] r;
    int g, ew, n, last;
    tbl[0] = '{4'b0001, 16'd48, 16'd18, 4, 0, 16'd6};
    tbl[1] = '{4'b0011, 16'd100, 16'd75, 2, 1, 16'd25};
    tbl[2] = '{4'b1001, 16'd17, 16'd5, 1, 3, 16'd1};
    tbl[3] = '{4'b1010, 16'd270, 16'd192, 3, 1, 16'd6};
    tbl[4] = '{4'b0100, 16'd0, 16'd12, 2, 2, 16'd12};
    tbl[5] = '{4'b0001, 16'hffff, 16'hffff, 1, 0, 16'hffff};
    do_reset(4'b0000);
    tick;
    check("idle after reset", {busy, gnt, rsp_valid}, 0);
    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].r, {4{tbl[i].a}}, {4{tbl[i].b}}, tbl[i].d, tbl[i].w, tbl[i].exp, $sformatf("vec%0d", i));
    // round robin with all requests held from reset
    opa = {16'd40, 16'd30, 16'd20, 16'd10};
    opb = {16'd8, 16'd6, 16'd4, 16'd2};
    eng_delay = 1;
    do_reset(4'b1111);
    last = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 0 && n < 20) begin
        tick;
        n++;
      end
      check($sformatf("rr grant %0d", k), gnt, 64'(1 << (k % 4)));
      if (k > 0) check($sformatf("rr gap %0d", k), cyc - last, 4);
      last = cyc;
      if (k == 4) req = '0;
      tick;
    end
    n = 0;
    while (busy && n < 20) begin
      tick;
      n++;
    end
    check("rr drained", busy, 0);
    model_ptr = 1;
    // randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int l = 0; l < 4; l++) begin
        g = $urandom_range(1, 60);
        ra[l*16 +: 16] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'(g * $urandom_range(1, 1000));
        rb[l*16 +: 16] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'(g * $urandom_range(1, 1000));
      end
      ew = rr(r, model_ptr);
      run_txn(r, ra, rb, $urandom_range(1, 6), ew, gcd(ra[ew*16 +: 16], rb[ew*16 +: 16]), $sformatf("rand%0d", t));
    end
    // done asserted during ISSUE must be ignored
    eng_auto = 1'b0;
    eng_done = 1'b0;
    rv_cnt = 0;
    opa = {4{16'd10}};
    opb = {4{16'd15}};
    req = 4'b0001;
    tick;
    check("early gnt", gnt, 1);
    eng_done = 1'b1;
    eng_result = 16'd77;
    req = '0;
    tick;
    check("early ignored", rsp_valid, 0);
    eng_done = 1'b0;
    tick;
    tick;
    check("early still waiting", {busy, rsp_valid}, 5'b10000);
    eng_done = 1'b1;
    eng_result = 16'd5;
    tick;
    eng_done = 1'b0;
    check("late rsp_valid", rsp_valid, 1);
    check("late rsp_data", rsp_data, 5);
    for (int i = 0; i < 5; i++) tick;
    check("single response", rv_cnt, 1);
    eng_auto = 1'b1;
    model_ptr = 1;
    // operand change after grant
    opa = {4{16'd21}};
    opb = {4{16'd14}};
    eng_delay = 5;
    req = 4'b0001;
    tick;
    check("opchg gnt", gnt, 1);
    req = '0;
    opa[15:0] = 16'd99;
    n = 0;
    while (rsp_valid == 0 && n < 12) begin
      check("opchg eng_a", eng_a, 21);
      tick;
      n++;
    end
    check("opchg rsp_valid", rsp_valid, 1);
    check("opchg rsp_data", rsp_data, 7);
    tick;
    // reset while waiting on the engine
    opa = {16'd9, 16'd30, 16'd9, 16'd12};
    opb = {16'd3, 16'd45, 16'd3, 16'd8};
    eng_delay = 10;
    req = 4'b0100;
    tick;
    check("rstw gnt", gnt, 4'b0100);
    req = '0;
    tick;
    tick;
    rv_cnt = 0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("rstw immediate");
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick;
    check("rstw no response", rv_cnt, 0);
    run_txn(4'b0101, opa, opb, 2, 0, 16'd4, "rstw next");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
